// File: rtl/seq_det_pkg.sv
// seq_det_pkg: shared types, pattern constant and round-robin pick helper
package seq_det_pkg;
   typedef enum logic [2:0] {S0, S1, S2, S3, S4} det_state_t;
   typedef enum logic [1:0] {IDLE, SHIFT, DRAIN, RESP} sched_state_t;
   localparam logic [3:0] PATTERN = 4'b1101;
   localparam int MAXREQ = 32;
   // One-hot grant for the first valid requester at or after ptr, wrapping modulo n.
   function automatic logic [MAXREQ-1:0] rr_pick(input logic [MAXREQ-1:0] valid, input int ptr, input int n);
      logic [MAXREQ-1:0] grant;
      int idx;
      grant = '0;
      for (int k = n - 1; k >= 0; k--) begin
         idx = ptr + k;
         if (idx >= n) idx = idx - n;
         if (valid[idx]) grant = MAXREQ'(1) << idx;
      end
      return grant;
   endfunction
endpackage

// File: rtl/seq_det_core.sv
// seq_det_core: Moore overlapping 1101 detector with synchronous clear and bit enable
module seq_det_core
   import seq_det_pkg::*;
(
   input  logic clk,
   input  logic reset,
   input  logic clr,
   input  logic bit_en,
   input  logic bit_in,
   output logic out
);
   det_state_t r_state, w_next;
   // state register; clear wins over an enabled bit
   always_ff @(posedge clk or posedge reset)
      if (reset) r_state <= S0;
      else r_state <= clr ? S0 : w_next;
   // next state, advancing only on enabled bits
   always_comb begin
      w_next = r_state;
      if (bit_en)
         case (r_state)
            S0:      w_next = (bit_in == PATTERN[3]) ? S1 : S0;
            S1:      w_next = (bit_in == PATTERN[2]) ? S2 : S0;
            S2:      w_next = (bit_in == PATTERN[1]) ? S3 : S2;
            S3:      w_next = (bit_in == PATTERN[0]) ? S4 : S0;
            S4:      w_next = bit_in ? S2 : S0;
            default: w_next = S0;
         endcase
   end
   assign out = (r_state == S4);
endmodule

// File: rtl/seq_det_sched.sv
// seq_det_sched: round-robin scheduler feeding request words serially through one 1101 detector
module seq_det_sched
   import seq_det_pkg::*;
#(
   parameter  int NREQ  = 4,
   parameter  int WIDTH = 16,
   localparam int IDW   = $clog2(NREQ),
   localparam int CW    = $clog2(WIDTH + 1)
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic [NREQ-1:0]       req_valid,
   input  logic [NREQ*WIDTH-1:0] req_data,
   output logic [NREQ-1:0]       req_ready,
   output logic                  rsp_valid,
   output logic [IDW-1:0]        rsp_id,
   output logic [CW-1:0]         rsp_count,
   input  logic                  rsp_ready,
   output logic                  busy
);
   sched_state_t      r_state, w_next;
   logic [IDW-1:0]    r_ptr, r_id, w_gidx;
   logic [CW-1:0]     r_count, r_bits;
   logic [WIDTH-1:0]  r_shift;
   logic              r_rsp_valid;
   logic [MAXREQ-1:0] w_pick;
   logic              w_clr, w_bit_en, w_det, w_last, w_hs;

   assign w_pick    = rr_pick(MAXREQ'(req_valid), int'(r_ptr), NREQ);
   assign w_last    = (r_bits == CW'(WIDTH - 1));
   assign w_hs      = r_rsp_valid & rsp_ready;
   assign rsp_valid = r_rsp_valid;
   assign rsp_id    = r_id;
   assign rsp_count = r_count;

   // binary index of the current one-hot grant
   always_comb begin
      w_gidx = '0;
      for (int i = 0; i < NREQ; i++)
         if (w_pick[i]) w_gidx = IDW'(i);
   end

   // scheduler state register
   always_ff @(posedge clk or posedge reset)
      if (reset) r_state <= IDLE;
      else r_state <= w_next;

   // scheduler next state
   always_comb begin
      w_next = r_state;
      case (r_state)
         IDLE:    w_next = w_clr ? SHIFT : IDLE;
         SHIFT:   w_next = w_last ? DRAIN : SHIFT;
         DRAIN:   w_next = RESP;
         RESP:    w_next = w_hs ? IDLE : RESP;
         default: w_next = IDLE;
      endcase
   end

   // grant is only offered while idle, so a single word is ever in flight
   always_comb begin
      req_ready = (r_state == IDLE) ? w_pick[NREQ-1:0] : '0;
      w_clr     = (r_state == IDLE) && (|w_pick);
      w_bit_en  = (r_state == SHIFT);
      busy      = (r_state != IDLE);
   end

   // word capture, serialization, match counting and response bookkeeping
   always_ff @(posedge clk or posedge reset)
      if (reset) begin
         r_ptr       <= '0;
         r_id        <= '0;
         r_count     <= '0;
         r_bits      <= '0;
         r_shift     <= '0;
         r_rsp_valid <= 1'b0;
      end else begin
         if (w_clr) begin
            r_shift <= req_data[int'(w_gidx)*WIDTH +: WIDTH];
            r_id    <= w_gidx;
            r_count <= '0;
            r_bits  <= '0;
         end
         if (w_bit_en) begin
            r_shift <= r_shift << 1;
            r_bits  <= r_bits + CW'(1);
         end
         if ((w_bit_en || r_state == DRAIN) && w_det) r_count <= r_count + CW'(1);
         if (r_state == DRAIN) r_rsp_valid <= 1'b1;
         else if (w_hs) r_rsp_valid <= 1'b0;
         if (w_hs) r_ptr <= (r_id == IDW'(NREQ - 1)) ? '0 : r_id + IDW'(1);
      end

   seq_det_core u_core (
      .clk    (clk),
      .reset  (reset),
      .clr    (w_clr),
      .bit_en (w_bit_en),
      .bit_in (r_shift[WIDTH-1]),
      .out    (w_det)
   );
endmodule

// File: tb/tb_seq_det_sched.sv
// tb_seq_det_sched: vector table, corner sequences and randomized run against a transaction-level model
module tb_seq_det_sched;
   localparam int NREQ = 4, WIDTH = 16, IDW = 2, CW = 5;
   logic                  clk = 1'b0, reset = 1'b1, rsp_ready = 1'b0;
   logic [NREQ-1:0]       req_valid = '0, req_ready;
   logic [NREQ*WIDTH-1:0] req_data = '0;
   logic                  rsp_valid, busy;
   logic [IDW-1:0]        rsp_id;
   logic [CW-1:0]         rsp_count;
   int n_pass = 0, n_tot = 0;

   seq_det_sched #(.NREQ(NREQ), .WIDTH(WIDTH)) dut (
      .clk(clk), .reset(reset), .req_valid(req_valid), .req_data(req_data), .req_ready(req_ready),
      .rsp_valid(rsp_valid), .rsp_id(rsp_id), .rsp_count(rsp_count), .rsp_ready(rsp_ready), .busy(busy)
   );

   always #5 clk = ~clk;

   typedef struct {int id; logic [WIDTH-1:0] data; int cnt;} vec_t;
   vec_t vecs[9];

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_tot++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
   endtask

   function automatic int ref_count(input logic [WIDTH-1:0] d);
      int c = 0;
      for (int i = 0; i <= WIDTH - 4; i++)
         if (d[i +: 4] == 4'b1101) c++;
      return c;
   endfunction

   function automatic int ref_pick(input logic [NREQ-1:0] v, input int p);
      for (int k = 0; k < NREQ; k++)
         if (v[(p + k) % NREQ]) return (p + k) % NREQ;
      return -1;
   endfunction

   task automatic run_word(input int id, input logic [WIDTH-1:0] d, output int gid, output int gcnt, output int lat);
      int t = 0;
      req_valid = NREQ'(1) << id;
      req_data[id*WIDTH +: WIDTH] = d;
      rsp_ready = 1'b1;
      #1;
      while (req_ready == '0 && t < 50) begin @(negedge clk); #1; t++; end
      chk("accept_grant", 32'(req_ready), 32'(NREQ'(1) << id));
      @(negedge clk);
      req_valid = '0;
      lat = 1;
      #1;
      while (!rsp_valid && lat < 60) begin @(negedge clk); #1; lat++; end
      gid  = rsp_id;
      gcnt = rsp_count;
      @(negedge clk);
   endtask

   task automatic wait_rsp();
      int t = 0;
      #1;
      while (!rsp_valid && t < 60) begin @(negedge clk); #1; t++; end
      chk("rsp_timeout", 32'(rsp_valid), 32'd1);
   endtask

   initial begin
      int gid, gcnt, lat, m_ptr, acc, q_id, q_cnt, e;
      bit outst;
      vecs[0] = '{0, 16'hD000, 1};
      vecs[1] = '{2, 16'hDB6D, 5};
      vecs[2] = '{2, 16'hFFFF, 0};
      vecs[3] = '{2, 16'h0000, 0};
      vecs[4] = '{1, 16'h0006, 0};
      vecs[5] = '{1, 16'h8000, 0};
      vecs[6] = '{3, 16'h000D, 1};
      vecs[7] = '{0, 16'h1B00, 1};
      vecs[8] = '{3, 16'hDDDD, 4};
      repeat (3) @(negedge clk);
      #1;
      chk("rst_rsp_valid", 32'(rsp_valid), 0);
      chk("rst_rsp_id", 32'(rsp_id), 0);
      chk("rst_rsp_count", 32'(rsp_count), 0);
      chk("rst_busy", 32'(busy), 0);
      @(negedge clk);
      reset = 1'b0;
      foreach (vecs[i]) begin
         run_word(vecs[i].id, vecs[i].data, gid, gcnt, lat);
         chk("vec_id", 32'(gid), 32'(vecs[i].id));
         chk("vec_count", 32'(gcnt), 32'(vecs[i].cnt));
         chk("vec_latency", 32'(lat), 32'(WIDTH + 2));
      end
      // all requesters valid continuously: strict rotation from pointer 0
      reset = 1'b1;
      @(negedge clk);
      reset = 1'b0;
      req_data = {NREQ{16'hDB6D}};
      req_valid = '1;
      rsp_ready = 1'b1;
      for (int k = 0; k < 5; k++) begin
         int t = 0;
         #1;
         while (req_ready == '0 && t < 60) begin @(negedge clk); #1; t++; end
         chk("rr_grant", 32'(req_ready), 32'(NREQ'(1) << (k % NREQ)));
         @(negedge clk);
         wait_rsp();
         chk("rr_rsp_id", 32'(rsp_id), 32'(k % NREQ));
         @(negedge clk);
      end
      // response backpressure: outputs frozen while rsp_ready is low
      rsp_ready = 1'b0;
      #1;
      chk("bp_grant", 32'(req_ready), 32'b0010);
      @(negedge clk);
      wait_rsp();
      chk("bp_count", 32'(rsp_count), 5);
      gid = rsp_id;
      gcnt = rsp_count;
      repeat (5) begin
         @(negedge clk);
         #1;
         chk("bp_valid", 32'(rsp_valid), 1);
         chk("bp_id_stable", 32'(rsp_id), 32'(gid));
         chk("bp_count_stable", 32'(rsp_count), 32'(gcnt));
         chk("bp_ready_low", 32'(req_ready), 0);
         chk("bp_busy", 32'(busy), 1);
      end
      rsp_ready = 1'b1;
      @(negedge clk);
      req_valid = 4'b1000;
      #1;
      chk("bp_released_valid", 32'(rsp_valid), 0);
      chk("bp_released_busy", 32'(busy), 0);
      chk("bp_next_grant", 32'(req_ready), 32'b1000);
      // reset in the middle of a word; pointer must return to 0
      @(negedge clk);
      req_valid = '0;
      repeat (4) @(negedge clk);
      #1;
      chk("mid_shift_busy", 32'(busy), 1);
      reset = 1'b1;
      #1;
      chk("async_rst_valid", 32'(rsp_valid), 0);
      chk("async_rst_busy", 32'(busy), 0);
      chk("async_rst_id", 32'(rsp_id), 0);
      @(negedge clk);
      reset = 1'b0;
      req_valid = 4'b1001;
      #1;
      chk("post_rst_grant", 32'(req_ready), 32'b0001);
      @(negedge clk);
      req_valid = '0;
      wait_rsp();
      chk("post_rst_id", 32'(rsp_id), 0);
      chk("post_rst_count", 32'(rsp_count), 32'(ref_count(req_data[0 +: WIDTH])));
      // randomized traffic against the transaction-level model
      reset = 1'b1;
      @(negedge clk);
      reset = 1'b0;
      m_ptr = 0;
      outst = 1'b0;
      acc = 0;
      q_id = 0;
      q_cnt = 0;
      for (int cyc = 0; cyc < 3000; cyc++) begin
         req_valid = NREQ'($urandom_range(0, 15));
         for (int r = 0; r < NREQ; r++)
            case ($urandom_range(0, 3))
               0: req_data[r*WIDTH +: WIDTH] = 16'hDB6D;
               1: req_data[r*WIDTH +: WIDTH] = 16'hFFFF ^ (16'h1 << $urandom_range(0, 15));
               default: req_data[r*WIDTH +: WIDTH] = WIDTH'($urandom);
            endcase
         rsp_ready = ($urandom_range(0, 3) != 0);
         #1;
         if (!outst) begin
            e = ref_pick(req_valid, m_ptr);
            chk("rnd_grant", 32'(req_ready), (e < 0) ? 32'd0 : 32'(NREQ'(1) << e));
            chk("rnd_idle_busy", 32'(busy), 0);
            chk("rnd_idle_valid", 32'(rsp_valid), 0);
            if (e >= 0) begin
               outst = 1'b1;
               acc = cyc;
               q_id = e;
               q_cnt = ref_count(req_data[e*WIDTH +: WIDTH]);
            end
         end else begin
            chk("rnd_ready_low", 32'(req_ready), 0);
            chk("rnd_busy", 32'(busy), 1);
            chk("rnd_valid_timing", 32'(rsp_valid), 32'(cyc - acc >= WIDTH + 2));
            if (rsp_valid) begin
               chk("rnd_id", 32'(rsp_id), 32'(q_id));
               chk("rnd_count", 32'(rsp_count), 32'(q_cnt));
               if (rsp_ready) begin
                  outst = 1'b0;
                  m_ptr = (q_id + 1) % NREQ;
               end
            end
         end
         @(negedge clk);
      end
      $display("%0d/%0d checks passed", n_pass, n_tot);
      $finish;
   end
endmodule
